// File: rtl/spi_byte_transceiver.sv
// SPI mode-0 slave byte engine: synchronises SCLK/SS/MOSI into clk, assembles MSB-first bytes
// and shifts a transmit byte out on MISO. Define SPI_BYTE_ECHO_EN to loop received bytes back to MISO.
module spi_byte_transceiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hw_spi_clk,
    input  logic       hw_spi_ss,
    input  logic       hw_spi_mosi,
    output logic       hw_spi_miso,
    input  logic [7:0] tx_byte,
    output logic       tx_ack,
    output logic       spi_active,
    output logic [7:0] byte_out,
    output logic       byte_ready,
    output logic       frame_abort
);

    // Input synchroniser chains; index 0 samples the pin, the top index is the synchronised value.
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_d_reg;
    logic                   ss_d_reg;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic rise;
    logic fall;
    logic sel;
    logic desel;

    logic [2:0] bit_cnt_reg,     bit_cnt_next;
    logic [7:0] rx_shift_reg,    rx_shift_next;
    logic [7:0] tx_shift_reg,    tx_shift_next;
    logic [7:0] byte_out_reg,    byte_out_next;
    logic       byte_ready_reg,  byte_ready_next;
    logic       tx_ack_reg,      tx_ack_next;
    logic       frame_abort_reg, frame_abort_next;
    logic       spi_active_reg;
    logic       miso_reg,        miso_next;

    logic [7:0] rx_assembled;
    logic [7:0] load_on_sel;
    logic [7:0] load_on_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            ss_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            sclk_d_reg    <= 1'b0;
            ss_d_reg      <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], hw_spi_clk};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], hw_spi_ss};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], hw_spi_mosi};
            sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
            ss_d_reg      <= ss_sync_reg[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    assign rise  =  sclk_s & ~sclk_d_reg;
    assign fall  = ~sclk_s &  sclk_d_reg;
    assign sel   =  ss_d_reg & ~ss_s;
    assign desel = ~ss_d_reg &  ss_s;

    assign rx_assembled = {rx_shift_reg[6:0], mosi_s};

`ifdef SPI_BYTE_ECHO_EN
    // Loopback: a frame opens with the last byte seen, and each completed byte is echoed next.
    assign load_on_sel  = byte_out_reg;
    assign load_on_done = rx_assembled;
`else
    assign load_on_sel  = tx_byte;
    assign load_on_done = tx_byte;
`endif

    always_comb begin
        bit_cnt_next     = bit_cnt_reg;
        rx_shift_next    = rx_shift_reg;
        tx_shift_next    = tx_shift_reg;
        byte_out_next    = byte_out_reg;
        byte_ready_next  = 1'b0;
        tx_ack_next      = 1'b0;
        frame_abort_next = 1'b0;

        if (desel) begin
            // Deselect overrides any coincident SCLK edge; a partial byte is discarded.
            bit_cnt_next = 3'd0;
            if (bit_cnt_reg != 3'd0) begin
                frame_abort_next = 1'b1;
            end
        end else if (sel) begin
            bit_cnt_next  = 3'd0;
            tx_shift_next = load_on_sel;
            tx_ack_next   = 1'b1;
        end else if (!ss_s) begin
            if (rise) begin
                rx_shift_next = rx_assembled;
                bit_cnt_next  = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_out_next   = rx_assembled;
                    byte_ready_next = 1'b1;
                    tx_shift_next   = load_on_done;
                    tx_ack_next     = 1'b1;
                end
            end else if (fall && (bit_cnt_reg != 3'd0)) begin
                // The fall after a byte boundary is skipped so the new bit 7 stays on MISO.
                tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        miso_next = 1'b0;
        if (!ss_s) begin
            miso_next = tx_shift_reg[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg     <= 3'd0;
            rx_shift_reg    <= 8'd0;
            tx_shift_reg    <= 8'd0;
            byte_out_reg    <= 8'd0;
            byte_ready_reg  <= 1'b0;
            tx_ack_reg      <= 1'b0;
            frame_abort_reg <= 1'b0;
            spi_active_reg  <= 1'b0;
            miso_reg        <= 1'b0;
        end else begin
            bit_cnt_reg     <= bit_cnt_next;
            rx_shift_reg    <= rx_shift_next;
            tx_shift_reg    <= tx_shift_next;
            byte_out_reg    <= byte_out_next;
            byte_ready_reg  <= byte_ready_next;
            tx_ack_reg      <= tx_ack_next;
            frame_abort_reg <= frame_abort_next;
            spi_active_reg  <= ~ss_s;
            miso_reg        <= miso_next;
        end
    end

    assign hw_spi_miso = miso_reg;
    assign tx_ack      = tx_ack_reg;
    assign spi_active  = spi_active_reg;
    assign byte_out    = byte_out_reg;
    assign byte_ready  = byte_ready_reg;
    assign frame_abort = frame_abort_reg;

endmodule

// File: tb/tb_spi_byte_transceiver.sv
// Directed bench for spi_byte_transceiver: table of single-byte frames plus hand-written
// sequences for idle SCLK, chip-select timing, back-to-back bytes, aborts and mid-byte reset.
module tb_spi_byte_transceiver;

    logic       clk;
    logic       rst;
    logic       hw_spi_clk;
    logic       hw_spi_ss;
    logic       hw_spi_mosi;
    logic       hw_spi_miso;
    logic [7:0] tx_byte;
    logic       tx_ack;
    logic       spi_active;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       frame_abort;

    spi_byte_transceiver #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .hw_spi_clk  (hw_spi_clk),
        .hw_spi_ss   (hw_spi_ss),
        .hw_spi_mosi (hw_spi_mosi),
        .hw_spi_miso (hw_spi_miso),
        .tx_byte     (tx_byte),
        .tx_ack      (tx_ack),
        .spi_active  (spi_active),
        .byte_out    (byte_out),
        .byte_ready  (byte_ready),
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled away from the active edge.
    int         ready_cnt = 0;
    int         ack_cnt   = 0;
    int         abort_cnt = 0;
    logic [7:0] rx_log[$];
    time        ready_time[$];

    always @(negedge clk) begin
        if (byte_ready === 1'b1) begin
            ready_cnt++;
            rx_log.push_back(byte_out);
            ready_time.push_back($time);
        end
        if (tx_ack === 1'b1) ack_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 host: MOSI set while SCLK low, MISO sampled just before each rising edge.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 0; i < n; i++) begin
            hw_spi_mosi = b[7-i];
            wait_cycles(8);
            miso_b[7-i] = hw_spi_miso;
            hw_spi_clk = 1'b1;
            wait_cycles(8);
            hw_spi_clk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] m;
        int r0, a0, f0, base;

        vecs[0] = '{mosi: 8'hA5, tx: 8'h3C, exp_rx: 8'hA5, exp_miso: 8'h3C};
        vecs[1] = '{mosi: 8'h3C, tx: 8'hA5, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[2] = '{mosi: 8'h00, tx: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[3] = '{mosi: 8'hFF, tx: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[4] = '{mosi: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};

        rst = 1'b1;
        hw_spi_clk = 1'b0;
        hw_spi_ss = 1'b1;
        hw_spi_mosi = 1'b0;
        tx_byte = 8'h00;
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(1);

        check("reset_byte_out", byte_out, 8'h00);
        check("reset_byte_ready", byte_ready, 1'b0);
        check("reset_tx_ack", tx_ack, 1'b0);
        check("reset_frame_abort", frame_abort, 1'b0);
        check("reset_spi_active", spi_active, 1'b0);
        check("reset_miso", hw_spi_miso, 1'b0);

        // SCLK toggling with SS high must be ignored.
        hw_spi_mosi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hw_spi_clk = 1'b1;
            wait_cycles(8);
            hw_spi_clk = 1'b0;
            wait_cycles(8);
        end
        check("idle_ready_cnt", ready_cnt, 0);
        check("idle_ack_cnt", ack_cnt, 0);
        check("idle_abort_cnt", abort_cnt, 0);
        check("idle_spi_active", spi_active, 1'b0);
        check("idle_miso", hw_spi_miso, 1'b0);

        // Table of single-byte frames.
        for (int v = 0; v < 5; v++) begin
            tx_byte = vecs[v].tx;
            r0 = ready_cnt; a0 = ack_cnt; f0 = abort_cnt;
            hw_spi_ss = 1'b0;
            if (v == 0) begin
                wait_cycles(2);
                check("ss_active_early", spi_active, 1'b0);
                wait_cycles(1);
                check("ss_active_on_time", spi_active, 1'b1);
                wait_cycles(5);
            end else begin
                wait_cycles(8);
            end
            send_bits(vecs[v].mosi, 8, m);
            wait_cycles(8);
            hw_spi_ss = 1'b1;
            wait_cycles(8);
            check($sformatf("vec%0d_ready_cnt", v), ready_cnt - r0, 1);
            check($sformatf("vec%0d_byte_out", v), byte_out, vecs[v].exp_rx);
            check($sformatf("vec%0d_ack_cnt", v), ack_cnt - a0, 2);
            check($sformatf("vec%0d_abort_cnt", v), abort_cnt - f0, 0);
`ifndef SPI_BYTE_ECHO_EN
            check($sformatf("vec%0d_miso", v), m, vecs[v].exp_miso);
`endif
        end
        check("idle_after_table_active", spi_active, 1'b0);

        // Back-to-back bytes in one frame.
        r0 = ready_cnt;
        base = rx_log.size();
        hw_spi_ss = 1'b0;
        wait_cycles(8);
        send_bits(8'h01, 8, m);
        send_bits(8'h23, 8, m);
        send_bits(8'h45, 8, m);
        wait_cycles(8);
        hw_spi_ss = 1'b1;
        wait_cycles(8);
        check("b2b_ready_cnt", ready_cnt - r0, 3);
        if (rx_log.size() >= base + 3) begin
            check("b2b_byte0", rx_log[base], 8'h01);
            check("b2b_byte1", rx_log[base+1], 8'h23);
            check("b2b_byte2", rx_log[base+2], 8'h45);
            check("b2b_gap01", 32'(ready_time[base+1] - ready_time[base]), 32'd1280);
            check("b2b_gap12", 32'(ready_time[base+2] - ready_time[base+1]), 32'd1280);
        end else begin
            check("b2b_log_size", rx_log.size() - base, 3);
        end

        // Abort after five bits: no byte, byte_out held, then a clean frame.
        r0 = ready_cnt; f0 = abort_cnt;
        hw_spi_ss = 1'b0;
        wait_cycles(8);
        send_bits(8'hFF, 5, m);
        wait_cycles(8);
        hw_spi_ss = 1'b1;
        wait_cycles(8);
        check("abort_cnt", abort_cnt - f0, 1);
        check("abort_ready_cnt", ready_cnt - r0, 0);
        check("abort_byte_out_held", byte_out, 8'h45);
        r0 = ready_cnt; f0 = abort_cnt;
        hw_spi_ss = 1'b0;
        wait_cycles(8);
        send_bits(8'h0F, 8, m);
        wait_cycles(8);
        hw_spi_ss = 1'b1;
        wait_cycles(8);
        check("post_abort_ready_cnt", ready_cnt - r0, 1);
        check("post_abort_byte_out", byte_out, 8'h0F);
        check("post_abort_abort_cnt", abort_cnt - f0, 0);

        // Reset mid-byte with SS held low.
        r0 = ready_cnt; f0 = abort_cnt;
        hw_spi_ss = 1'b0;
        wait_cycles(8);
        send_bits(8'hE0, 3, m);
        rst = 1'b1;
        wait_cycles(2);
        check("rst_mid_byte_out", byte_out, 8'h00);
        check("rst_mid_spi_active", spi_active, 1'b0);
        rst = 1'b0;
        wait_cycles(2);
        check("rst_rel_active_early", spi_active, 1'b0);
        wait_cycles(1);
        check("rst_rel_active_on_time", spi_active, 1'b1);
        check("rst_mid_no_ready", ready_cnt - r0, 0);
        wait_cycles(8);
        send_bits(8'h5A, 8, m);
        wait_cycles(8);
        hw_spi_ss = 1'b1;
        wait_cycles(8);
        check("rst_resume_ready_cnt", ready_cnt - r0, 1);
        check("rst_resume_byte_out", byte_out, 8'h5A);
        check("rst_no_abort", abort_cnt - f0, 0);

`ifdef SPI_BYTE_ECHO_EN
        // Echo: after reset byte_out is 0, so MISO returns 0x00 then 0x11.
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(4);
        begin
            logic [7:0] m0, m1;
            hw_spi_ss = 1'b0;
            wait_cycles(8);
            send_bits(8'h11, 8, m0);
            send_bits(8'h22, 8, m1);
            wait_cycles(8);
            hw_spi_ss = 1'b1;
            wait_cycles(8);
            check("echo_first", m0, 8'h00);
            check("echo_second", m1, 8'h11);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
